// File: rtl/rand_stream_src_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rand_stream_src_pkg
//  Brief    : Shared constants and FSM encoding for the random stream source.
//  Revision : 1.0  initial release
// ============================================================================
package rand_stream_src_pkg;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] c_LFSR_MASK    = 32'h8020_0003;
  // Substituted for an all-zero seed so the LFSR never locks up
  localparam logic [31:0] c_DEFAULT_SEED = 32'h0000_0001;

  // FSM encoding
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = c_ST_IDLE,
    ST_RUN  = c_ST_RUN,
    ST_DONE = c_ST_DONE
  } state_t;

endpackage : rand_stream_src_pkg
`default_nettype wire

// File: rtl/rand_stream_src_if.sv
`default_nettype none
// ============================================================================
//  Module   : rand_stream_src_if
//  Brief    : Valid/ready word stream between the source and its sink.
//  Revision : 1.0  initial release
// ============================================================================
interface rand_stream_src_if #(
  parameter int DATA_W = 32
) ();

  logic [DATA_W-1:0] x_out;
  logic              x_valid;
  logic              x_ready;

  modport master (output x_out, output x_valid, input x_ready);
  modport slave  (input x_out, input x_valid, output x_ready);

endinterface : rand_stream_src_if
`default_nettype wire

// File: rtl/rand_stream_src_lfsr32_next.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr32_next
//  Brief    : Combinational next-state of a 32-bit Galois LFSR (right shift,
//             mask XORed in when the outgoing lsb is 1).
//  Revision : 1.0  initial release
// ============================================================================
module lfsr32_next
  import rand_stream_src_pkg::*;
#(
  parameter logic [31:0] MASK = c_LFSR_MASK
) (
  input  wire logic [31:0] i_state,
  output logic      [31:0] o_next
);

  // Shift right; fold the feedback mask in when a 1 falls off the end
  always_comb begin
    o_next = i_state[0] ? ((i_state >> 1) ^ MASK) : (i_state >> 1);
  end

endmodule : lfsr32_next
`default_nettype wire

// File: rtl/rand_stream_src.sv
`default_nettype none
// ============================================================================
//  Module   : rand_stream_src
//  Brief    : Bounded stream of pseudo-random 32-bit words on a valid/ready
//             port, with burst control and a running unsigned maximum of the
//             words accepted by the sink.
//  Revision : 1.0  initial release
// ============================================================================
module rand_stream_src
  import rand_stream_src_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] LFSR_MASK = c_LFSR_MASK
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_en,
  input  wire logic              i_start,
  input  wire logic [DATA_W-1:0] i_seed,
  input  wire logic [CNT_W-1:0]  i_count,
  rand_stream_src_if.master      m_if,
  output logic                   o_busy,
  output logic                   o_done,
  output logic      [DATA_W-1:0] o_max_out
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_lfsr;
  logic [CNT_W-1:0]   r_remaining;
  logic [DATA_W-1:0]  r_max;
  logic               r_zero_done;

  logic [DATA_W-1:0]  w_lfsr_next;
  logic               w_accept_start;
  logic               w_count_zero;
  logic               w_xfer;
  logic               w_last;

  // Next LFSR value, shared structure with the verification checker
  lfsr32_next #(
    .MASK (LFSR_MASK)
  ) u_lfsr_next (
    .i_state (r_lfsr),
    .o_next  (w_lfsr_next)
  );

  // Handshake qualifiers; a transfer only happens while enabled
  always_comb begin
    w_accept_start = (r_state == ST_IDLE) && i_en && i_start;
    w_count_zero   = (i_count == '0);
    w_xfer         = (r_state == ST_RUN) && m_if.x_ready && i_en;
    w_last         = (r_remaining == CNT_W'(1));
  end

  // State register; everything freezes while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (i_en) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept_start && !w_count_zero) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_xfer && w_last)                w_state_nxt = ST_DONE;
      ST_DONE:                                      w_state_nxt = ST_IDLE;
      default:                                      w_state_nxt = ST_IDLE;
    endcase
  end

  // Burst datapath: seed/count capture, word advance, running maximum
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr      <= '0;
      r_remaining <= '0;
      r_max       <= '0;
      r_zero_done <= 1'b0;
    end else if (i_en) begin
      // A zero-length request still answers with a single done pulse
      r_zero_done <= w_accept_start && w_count_zero;
      if (w_accept_start && !w_count_zero) begin
        r_lfsr      <= (i_seed == '0) ? DATA_W'(c_DEFAULT_SEED) : i_seed;
        r_remaining <= i_count;
        r_max       <= '0;
      end else if (w_xfer) begin
        if (r_lfsr > r_max) r_max <= r_lfsr;
        r_remaining <= r_remaining - CNT_W'(1);
        r_lfsr      <= w_lfsr_next;
      end
    end
  end

  // Outputs decoded from state and registers
  always_comb begin
    m_if.x_out   = r_lfsr;
    m_if.x_valid = (r_state == ST_RUN);
    o_busy       = (r_state == ST_RUN);
    o_done       = (r_state == ST_DONE) || r_zero_done;
    o_max_out    = r_max;
  end

endmodule : rand_stream_src
`default_nettype wire

// File: tb/tb_rand_stream_src.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rand_stream_src
//  Brief    : Self-checking bench for rand_stream_src against a behavioural
//             burst model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rand_stream_src;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic [31:0] seed;
  logic [15:0] count;
  logic        busy;
  logic        done;
  logic [31:0] max_out;

  rand_stream_src_if #(.DATA_W(32)) bus ();

  rand_stream_src dut (
    .clk       (clk),
    .rst       (rst),
    .i_en      (en),
    .i_start   (start),
    .i_seed    (seed),
    .i_count   (count),
    .m_if      (bus.master),
    .o_busy    (busy),
    .o_done    (done),
    .o_max_out (max_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model
  bit          m_run;
  bit          m_done_state;
  bit          m_done;
  int          m_left;
  logic [31:0] m_word;
  logic [31:0] m_max;
  int          exp_xfers;
  int          obs_xfers;
  int          obs_dones;
  int          exp_dones;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, advance the model, check all outputs after edge
  task automatic step(input string tag, input bit r, input bit e, input bit s,
                      input logic [31:0] sd, input logic [15:0] cnt, input bit rdy);
    bit nd, zd;
    rst = r; en = e; start = s; seed = sd; count = cnt; bus.x_ready = rdy;
    #1;
    if (bus.x_valid && rdy && e && !r) obs_xfers++;
    if (r) begin
      m_run = 0; m_done_state = 0; m_done = 0; m_left = 0; m_word = '0; m_max = '0;
    end else if (e) begin
      nd = 0; zd = 0;
      if (m_run) begin
        if (rdy) begin
          exp_xfers++;
          if (m_word > m_max) m_max = m_word;
          m_word = lfsr_step(m_word);
          m_left--;
          if (m_left == 0) begin m_run = 0; nd = 1; end
        end
      end else if (!m_done_state && s) begin
        if (cnt != 0) begin
          m_run = 1; m_left = int'(cnt); m_word = (sd == 0) ? 32'd1 : sd; m_max = '0;
        end else begin
          zd = 1;
        end
      end
      m_done_state = nd;
      m_done = nd | zd;
      if (m_done) exp_dones++;
    end
    @(posedge clk);
    #1;
    if (done && e && !r) obs_dones++;
    chk({tag, ".valid"}, {31'd0, bus.x_valid}, {31'd0, m_run});
    chk({tag, ".busy"},  {31'd0, busy},        {31'd0, m_run});
    chk({tag, ".done"},  {31'd0, done},        {31'd0, m_done});
    chk({tag, ".x_out"}, bus.x_out, m_word);
    chk({tag, ".max"},   max_out, m_max);
  endtask

  task automatic clear_counts();
    obs_xfers = 0; exp_xfers = 0; obs_dones = 0; exp_dones = 0;
  endtask

  initial begin
    logic [31:0] rs;
    rst = 1; en = 1; start = 0; seed = 0; count = 0; bus.x_ready = 0;
    m_run = 0; m_done_state = 0; m_done = 0; m_left = 0; m_word = '0; m_max = '0;
    clear_counts();
    @(negedge clk);

    // Reset state
    step("reset", 1, 1, 0, 0, 0, 0);
    chk("reset.x_out_zero", bus.x_out, 32'h0);

    // Basic sequence: seed 1, count 4, ready high
    clear_counts();
    step("basic.start", 0, 1, 1, 32'd1, 16'd4, 1);
    chk("basic.w0", bus.x_out, 32'h0000_0001);
    step("basic.t1", 0, 1, 0, 0, 0, 1);
    chk("basic.w1", bus.x_out, 32'h8020_0003);
    step("basic.t2", 0, 1, 0, 0, 0, 1);
    chk("basic.w2", bus.x_out, 32'hC030_0002);
    step("basic.t3", 0, 1, 0, 0, 0, 1);
    chk("basic.w3", bus.x_out, 32'h6018_0001);
    step("basic.t4", 0, 1, 0, 0, 0, 1);
    chk("basic.done", {31'd0, done}, 32'd1);
    chk("basic.max", max_out, 32'hC030_0002);
    step("basic.idle", 0, 1, 0, 0, 0, 1);
    chk("basic.xfers", obs_xfers, 4);

    // Zero seed substituted with 1
    step("zseed.start", 0, 1, 1, 32'd0, 16'd2, 1);
    chk("zseed.w0", bus.x_out, 32'h0000_0001);
    step("zseed.t1", 0, 1, 0, 0, 0, 1);
    chk("zseed.w1", bus.x_out, 32'h8020_0003);
    step("zseed.t2", 0, 1, 0, 0, 0, 1);
    step("zseed.idle", 0, 1, 0, 0, 0, 1);

    // Backpressure: ready 1,0,0,1,1
    clear_counts();
    step("bp.start", 0, 1, 1, 32'd1, 16'd3, 0);
    step("bp.r1", 0, 1, 0, 0, 0, 1);
    step("bp.r0a", 0, 1, 0, 0, 0, 0);
    chk("bp.hold_a", bus.x_out, 32'h8020_0003);
    step("bp.r0b", 0, 1, 0, 0, 0, 0);
    chk("bp.hold_b", bus.x_out, 32'h8020_0003);
    step("bp.r1b", 0, 1, 0, 0, 0, 1);
    step("bp.r1c", 0, 1, 0, 0, 0, 1);
    step("bp.idle", 0, 1, 0, 0, 0, 1);
    chk("bp.xfers", obs_xfers, 3);
    chk("bp.dones", obs_dones, 1);

    // Enable stall mid-burst, ready held high (not a transfer while en=0)
    clear_counts();
    step("stall.start", 0, 1, 1, 32'h1234_5678, 16'd5, 1);
    step("stall.t1", 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step("stall.en0", 0, 0, 1, 32'hFFFF_FFFF, 16'd9, 1);
    for (int i = 0; i < 5; i++) step("stall.resume", 0, 1, 0, 0, 0, 1);
    chk("stall.xfers", obs_xfers, 5);
    chk("stall.dones", obs_dones, 1);

    // Zero count: one done pulse, never valid
    clear_counts();
    step("zcnt.start", 0, 1, 1, 32'd7, 16'd0, 1);
    chk("zcnt.done", {31'd0, done}, 32'd1);
    step("zcnt.after", 0, 1, 0, 0, 0, 1);
    step("zcnt.after2", 0, 1, 0, 0, 0, 1);
    chk("zcnt.dones", obs_dones, 1);
    chk("zcnt.xfers", obs_xfers, 0);

    // Reset after two of five words
    clear_counts();
    step("rstmid.start", 0, 1, 1, 32'd1, 16'd5, 1);
    step("rstmid.t1", 0, 1, 0, 0, 0, 1);
    step("rstmid.t2", 0, 1, 0, 0, 0, 1);
    step("rstmid.rst", 1, 1, 0, 0, 0, 1);
    chk("rstmid.max0", max_out, 32'h0);
    step("rstmid.idle", 0, 1, 0, 0, 0, 1);
    chk("rstmid.nodone", obs_dones, 0);
    step("rstmid.restart", 0, 1, 1, 32'd1, 16'd2, 1);
    chk("rstmid.w0", bus.x_out, 32'h0000_0001);
    step("rstmid.t3", 0, 1, 0, 0, 0, 1);
    step("rstmid.t4", 0, 1, 0, 0, 0, 1);
    step("rstmid.idle2", 0, 1, 0, 0, 0, 1);

    // Start during RUN is ignored
    clear_counts();
    step("ign.start", 0, 1, 1, 32'hDEAD_BEEF, 16'd3, 1);
    step("ign.restart", 0, 1, 1, 32'd1, 16'd50, 1);
    step("ign.t2", 0, 1, 1, 32'd1, 16'd50, 1);
    step("ign.t3", 0, 1, 0, 0, 0, 1);
    step("ign.idle", 0, 1, 0, 0, 0, 1);
    chk("ign.xfers", obs_xfers, 3);
    chk("ign.dones", obs_dones, 1);

    // Long burst with random ready and occasional enable drops
    clear_counts();
    rs = $urandom;
    step("long.start", 0, 1, 1, rs, 16'd1000, 1);
    for (int i = 0; i < 6000 && (m_run || m_done); i++)
      step("long.run", 0, ($urandom_range(0, 7) != 0), 0, 0, 0, $urandom_range(0, 1) == 1);
    step("long.idle", 0, 1, 0, 0, 0, 1);
    chk("long.xfers_model", exp_xfers, 1000);
    chk("long.xfers", obs_xfers, 1000);
    chk("long.dones", obs_dones, 1);

    // Maximum count, no wrap
    clear_counts();
    step("max.start", 0, 1, 1, $urandom, 16'hFFFF, 1);
    for (int i = 0; i < 70000 && (m_run || m_done); i++)
      step("max.run", 0, 1, 0, 0, 0, 1);
    step("max.idle", 0, 1, 0, 0, 0, 1);
    chk("max.xfers", obs_xfers, 65535);
    chk("max.dones", obs_dones, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rand_stream_src
`default_nettype wire

// File: doc/rand_stream_src.md
Name: rand_stream_src

Overview:
- Stimulus source for the running-maximum datapath. Produces a bounded stream of 32-bit pseudo-random words on x_out, behaving as an RTL replacement for testbench-side random generation.
- Built around a 32-bit Galois LFSR, a word counter, and a valid/ready output handshake.
- Sits upstream of the max-tracking block; also reports the largest word it has emitted so the two ends can be cross-checked.

Parameters:
- DATA_W, 32, width of emitted word and LFSR state; fixed at 32 (mask is 32-bit).
- CNT_W, 16, width of the word-count request and counter.
- LFSR_MASK, 32'h80200003, Galois feedback mask for x^32+x^22+x^2+x+1.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; when 0 all state holds, outputs hold.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE with en=1.
- seed  in  DATA_W  LFSR seed, captured on accepted start.
- count  in  CNT_W  number of words to emit, captured on accepted start.
- x_out  out  DATA_W  current word (LFSR state).
- x_valid  out  1  x_out holds a valid word.
- x_ready  in  1  sink accepts x_out this cycle.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after the last word is accepted.
- max_out  out  DATA_W  unsigned maximum of words accepted in the current/last burst.

Behaviour:
- Reset (rst=1 at a clk edge, regardless of en): state=IDLE, x_out=0, x_valid=0, busy=0, done=0, max_out=0, counter=0. Reset mid-burst aborts the burst with no done pulse.
- en=0: no register changes. Handshake transfers require en=1, so x_valid held with x_ready=1 and en=0 is not a transfer.
- Transfer: x_valid & x_ready & en at a rising edge.
- FSM IDLE:
  - start&en with count!=0: load lfsr=(seed==0 ? 1 : seed) and remaining=count; go to RUN next cycle with x_valid=1, busy=1.
  - start with count==0: emit a done pulse the next cycle and stay IDLE; max_out unchanged.
  - start while not IDLE: ignored.
- FSM RUN: x_valid=1; x_out=lfsr, stable while not accepted.
  - On transfer: max_out=max(max_out,x_out) (unsigned); remaining-=1; lfsr=next(lfsr).
  - If remaining was 1: go to DONE.
- FSM DONE: x_valid=0, busy=0, done=1 for exactly one cycle, then IDLE.
- max_out clears to 0 on an accepted start with count!=0, and holds after the burst.
- LFSR next-state: if lsb=1, (s>>1)^LFSR_MASK, else s>>1. State never becomes 0.
- Latency: start-to-first-valid is 1 cycle. Throughput is 1 word/cycle with x_ready held high. Last transfer-to-done is 1 cycle.
- A count of 2^CNT_W-1 must be supported without wrap; the counter never underflows.

Decomposition:
- Shared package holds:
  - LFSR_MASK and DEFAULT_SEED (32'h00000001) constants.
  - FSM state encoding (IDLE, RUN, DONE as a 2-bit localparam set).
- Natural sub-module: lfsr32_next, a purely combinational next-state function. It is reused by the verification model and later by an on-chip checker.

Test Plan:
- Basic sequence: reset, seed=1, count=4, x_ready=1. Required response:
  - x_out sequence 0x00000001, 0x80200003, 0xC0300002, 0x60180001 on consecutive cycles.
  - done one cycle after the 4th word; max_out=0xC0300002.
- Zero seed: seed=0, count=2 -> words 0x00000001, 0x80200003 (zero seed substituted).
- Backpressure: seed=1, count=3, x_ready toggling 1,0,0,1,1. Required response:
  - x_out holds 0x80200003 through the stall; exactly 3 transfers; done after the 3rd.
- Enable stall and zero count:
  - en=0 for 5 cycles mid-burst -> no state change, no transfers, sequence resumes unchanged.
  - start with count=0 -> single done pulse, x_valid never asserted.
- Reset mid-operation: rst=1 during RUN after 2 of 5 words. Required response:
  - Next cycle x_valid=0, busy=0, max_out=0, no done pulse.
  - A following start with seed=1 restarts at 0x00000001.
- Ignored start and long burst:
  - start asserted during RUN -> ignored; count and seed unchanged.
  - count=1000 with random x_ready -> 1000 transfers, match against model, done once.
